// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Program counter and instruction-fetch front end for bb_core. The block
//   fetches one instruction at a time from instruction memory and holds it
//   for decode. It accepts jump redirects from the ALU jump logic and exports
//   PC+1 (NPC) as the fall-through address.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous reset, asserted HIGH despite the name
//   i_jump_valid   one-cycle redirect pulse
//   i_jump_addr    redirect target, sampled only with i_jump_valid
//   o_mem_req      instruction memory read request
//   o_mem_addr     read address (always equals the PC)
//   i_mem_ack      memory accepts the request; i_mem_rdata valid same cycle
//   i_mem_rdata    fetched instruction word
//   o_instr_valid  o_instr holds an instruction for decode
//   o_instr        instruction register
//   i_instr_ready  decode consumes o_instr this cycle (qualified by valid)
//   o_pc           address of the current or in-flight instruction
//   o_npc          o_pc + 1, wrapping at 2^DATA_WIDTH
//   o_dbg_state    current FSM state (0 IDLE, 1 REQ, 2 HOLD)
//
// Handshakes
//   Memory side: a transfer happens on any rising edge where o_mem_req and
//   i_mem_ack are both 1. While o_mem_req is 1 and no ack has arrived,
//   o_mem_req and o_mem_addr do not change.
//   Decode side: a transfer happens on any rising edge where o_instr_valid
//   and i_instr_ready are both 1 and no jump is present. While the instruction
//   is not taken, o_instr and o_instr_valid are held. A jump withdraws the
//   held instruction instead.
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int unsigned                  DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0]        RESET_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_jump_valid,
  input  logic [DATA_WIDTH-1:0] i_jump_addr,
  output logic                  o_mem_req,
  output logic [DATA_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_instr_valid,
  output logic [DATA_WIDTH-1:0] o_instr,
  input  logic                  i_instr_ready,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_npc,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_instr;
  logic                  r_instr_valid;
  logic                  r_flush;      // in-flight request belongs to a stale path
  logic [DATA_WIDTH-1:0] r_pend_addr;  // redirect target waiting for that ack

  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] w_pc_nxt;
  logic [DATA_WIDTH-1:0] w_instr_nxt;
  logic                  w_instr_valid_nxt;
  logic                  w_flush_nxt;
  logic [DATA_WIDTH-1:0] w_pend_addr_nxt;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_ADDR;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_flush       <= 1'b0;
      r_pend_addr   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_flush       <= w_flush_nxt;
      r_pend_addr   <= w_pend_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_instr_nxt       = r_instr;
    w_instr_valid_nxt = r_instr_valid;
    w_flush_nxt       = r_flush;
    w_pend_addr_nxt   = r_pend_addr;

    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (i_jump_valid) begin
          w_pc_nxt = i_jump_addr;
        end
      end

      S_REQ: begin
        if (i_mem_ack) begin
          if (i_jump_valid) begin
            // A jump alongside the ack supersedes both the returned word and
            // any earlier pending redirect.
            w_pc_nxt    = i_jump_addr;
            w_flush_nxt = 1'b0;
          end else if (r_flush) begin
            // Stale word: drop it and re-request on the redirected path.
            w_pc_nxt    = r_pend_addr;
            w_flush_nxt = 1'b0;
          end else begin
            w_instr_nxt       = i_mem_rdata;
            w_instr_valid_nxt = 1'b1;
            w_state_nxt       = S_HOLD;
          end
        end else if (i_jump_valid) begin
          // The address must stay put until the ack, so park the target;
          // a later jump overwrites an earlier one.
          w_flush_nxt     = 1'b1;
          w_pend_addr_nxt = i_jump_addr;
        end
      end

      S_HOLD: begin
        if (i_jump_valid) begin
          w_pc_nxt          = i_jump_addr;
          w_instr_valid_nxt = 1'b0;
          w_state_nxt       = S_REQ;
        end else if (i_instr_ready) begin
          w_pc_nxt          = r_pc + DATA_WIDTH'(1);
          w_instr_valid_nxt = 1'b0;
          w_state_nxt       = S_REQ;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_mem_req     = (r_state == S_REQ);
  assign o_mem_addr    = r_pc;
  assign o_instr_valid = r_instr_valid;
  assign o_instr       = r_instr;
  assign o_pc          = r_pc;
  assign o_npc         = r_pc + DATA_WIDTH'(1);
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Directed bench for instr_fetch. The memory responder returns addr^A5A5
//   after a programmable wait. A program-flow model tracks which address
//   decode should see next, whether a fetch result is stale, and what is held.
//   From that it predicts o_mem_req, o_instr_valid, o_instr and o_pc every
//   cycle. The directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_jump_valid = 1'b0;
  logic [15:0] i_jump_addr = '0;
  logic        o_mem_req;
  logic [15:0] o_mem_addr;
  logic        i_mem_ack = 1'b0;
  logic [15:0] i_mem_rdata = '0;
  logic        o_instr_valid;
  logic [15:0] o_instr;
  logic        i_instr_ready = 1'b0;
  logic [15:0] o_pc;
  logic [15:0] o_npc;
  logic [1:0]  o_dbg_state;

  instr_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_jump_valid  (i_jump_valid),
    .i_jump_addr   (i_jump_addr),
    .o_mem_req     (o_mem_req),
    .o_mem_addr    (o_mem_addr),
    .i_mem_ack     (i_mem_ack),
    .i_mem_rdata   (i_mem_rdata),
    .o_instr_valid (o_instr_valid),
    .o_instr       (o_instr),
    .i_instr_ready (i_instr_ready),
    .o_pc          (o_pc),
    .o_npc         (o_npc),
    .o_dbg_state   (o_dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  // ---------------- memory responder ----------------
  int ack_delay = 0;
  bit ack_en    = 1'b1;
  bit force_ack = 1'b0;
  int wcnt      = 0;

  always begin
    @(negedge clk);
    #2;
    i_mem_rdata = mem_word(o_mem_addr);
    if (force_ack) begin
      i_mem_ack = 1'b1;
    end else if (o_mem_req && ack_en) begin
      if (wcnt >= ack_delay) begin
        i_mem_ack = 1'b1;
        wcnt      = 0;
      end else begin
        i_mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      i_mem_ack = 1'b0;
      if (!o_mem_req) wcnt = 0;
    end
  end

  // ---------------- program-flow model ----------------
  // m_addr: address whose instruction decode must see next.
  // m_req_addr: address the bus is actually presenting (lags m_addr while a
  // redirect waits for the outstanding ack).
  bit          m_started  = 1'b0;
  bit          m_valid    = 1'b0;
  bit          m_stale    = 1'b0;
  logic [15:0] m_addr     = '0;
  logic [15:0] m_req_addr = '0;
  logic [15:0] m_instr    = '0;

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      m_started  = 1'b0;
      m_valid    = 1'b0;
      m_stale    = 1'b0;
      m_addr     = 16'h0000;
      m_req_addr = 16'h0000;
    end else begin
      bit fetching;
      fetching = m_started && !m_valid;
      if (!m_started) begin
        m_started = 1'b1;
        if (i_jump_valid) m_addr = i_jump_addr;
      end else if (i_jump_valid) begin
        if (m_valid)       m_valid = 1'b0;
        else if (fetching) m_stale = !i_mem_ack;
        m_addr = i_jump_addr;
      end else if (fetching && i_mem_ack) begin
        if (m_stale) begin
          m_stale = 1'b0;
        end else begin
          m_valid = 1'b1;
          m_instr = mem_word(m_addr);
        end
      end else if (m_valid && i_instr_ready) begin
        m_valid = 1'b0;
        m_addr  = m_addr + 16'd1;
      end
      if (!m_stale) m_req_addr = m_addr;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("rst_req",   {31'd0, o_mem_req},     32'd0);
      chk("rst_valid", {31'd0, o_instr_valid}, 32'd0);
      chk("rst_instr", {16'd0, o_instr},       32'h0);
      chk("rst_pc",    {16'd0, o_pc},          32'h0);
      chk("rst_npc",   {16'd0, o_npc},         32'h1);
      chk("rst_addr",  {16'd0, o_mem_addr},    32'h0);
      chk("rst_state", {30'd0, o_dbg_state},   32'd0);
    end else begin
      logic [15:0] npc_exp;
      npc_exp = o_pc + 16'd1;
      chk("mdl_req",   {31'd0, o_mem_req},     {31'd0, (m_started && !m_valid)});
      chk("mdl_valid", {31'd0, o_instr_valid}, {31'd0, m_valid});
      chk("mdl_pc",    {16'd0, o_pc},          {16'd0, m_req_addr});
      chk("mdl_npc",   {16'd0, o_npc},         {16'd0, npc_exp});
      if (m_valid)   chk("mdl_instr", {16'd0, o_instr},    {16'd0, m_instr});
      if (o_mem_req) chk("mdl_addr",  {16'd0, o_mem_addr}, {16'd0, m_req_addr});
    end
  end

  // ---------------- consumed-instruction scoreboard ----------------
  logic        s_valid = 1'b0;
  logic [15:0] s_instr = '0;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  int          n_cons = 0;

  always @(negedge clk) begin
    s_valid = o_instr_valid;
    s_instr = o_instr;
  end

  always @(posedge clk) begin
    if (!rst_n && s_valid && i_instr_ready && !i_jump_valid) begin
      got_q.push_back(s_instr);
      n_cons++;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cons(input int n);
    int k;
    k = 0;
    while (n_cons < n && k < 200) begin
      step();
      k++;
    end
    chk("wait_cons", n_cons, n);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    exp_q = '{16'hA5A5, 16'hA5A4, 16'hA5A7, 16'hA5A6};

    // Reset, then free-running fetch with immediate acks.
    rst_n = 1'b1;
    repeat (3) step();
    rst_n         = 1'b0;
    i_instr_ready = 1'b1;

    wait_cons(5);
    chk("seq_len", got_q.size(), 5);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) chk("seq_instr", {16'd0, got_q[i]}, {16'd0, exp_q[i]});
    end

    // Wait-state fetch at address 5: request held for four cycles.
    ack_delay = 3;
    for (int i = 0; i < 4; i++) begin
      chk("ws_req",   {31'd0, o_mem_req},     32'd1);
      chk("ws_addr",  {16'd0, o_mem_addr},    32'h5);
      chk("ws_valid", {31'd0, o_instr_valid}, 32'd0);
      step();
    end
    chk("ws_valid_rise", {31'd0, o_instr_valid}, 32'd1);
    chk("ws_instr",      {16'd0, o_instr},       32'hA5A0);
    ack_delay = 0;

    // Jump in HOLD at pc=7 with ready in the same cycle.
    wait_cons(7);
    i_instr_ready = 1'b0;
    begin
      int k;
      k = 0;
      while (!(o_instr_valid && o_pc == 16'h7) && k < 50) begin
        step();
        k++;
      end
      chk("hold7_reached", {16'd0, o_pc}, 32'h7);
    end
    i_jump_valid  = 1'b1;
    i_jump_addr   = 16'h0040;
    i_instr_ready = 1'b1;
    step();
    i_jump_valid  = 1'b0;
    i_instr_ready = 1'b0;
    chk("j40_req",   {31'd0, o_mem_req},     32'd1);
    chk("j40_addr",  {16'd0, o_mem_addr},    32'h40);
    chk("j40_valid", {31'd0, o_instr_valid}, 32'd0);
    chk("j40_ncons", n_cons, 7);
    step();
    chk("j40_instr", {16'd0, o_instr},       32'hA5E5);
    chk("j40_pc",    {16'd0, o_pc},          32'h40);

    // Two jumps while the fetch at 3 is outstanding; the later one wins.
    i_jump_valid = 1'b1;
    i_jump_addr  = 16'h0003;
    ack_en       = 1'b0;
    step();
    i_jump_addr = 16'h0010;
    chk("fl_addr_a", {16'd0, o_mem_addr}, 32'h3);
    step();
    i_jump_addr = 16'h0020;
    chk("fl_addr_b", {16'd0, o_mem_addr}, 32'h3);
    step();
    i_jump_valid = 1'b0;
    ack_en       = 1'b1;
    chk("fl_addr_c",  {16'd0, o_mem_addr},    32'h3);
    chk("fl_valid_c", {31'd0, o_instr_valid}, 32'd0);
    step();
    chk("fl_req_new",  {31'd0, o_mem_req},     32'd1);
    chk("fl_addr_new", {16'd0, o_mem_addr},    32'h20);
    chk("fl_valid_d",  {31'd0, o_instr_valid}, 32'd0);
    step();
    chk("fl_valid", {31'd0, o_instr_valid}, 32'd1);
    chk("fl_instr", {16'd0, o_instr},       32'hA585);
    chk("fl_pc",    {16'd0, o_pc},          32'h20);

    // PC wrap at 0xFFFF.
    i_jump_valid = 1'b1;
    i_jump_addr  = 16'hFFFF;
    step();
    i_jump_valid = 1'b0;
    chk("wr_addr", {16'd0, o_mem_addr}, 32'hFFFF);
    chk("wr_npc",  {16'd0, o_npc},      32'h0);
    step();
    chk("wr_valid", {31'd0, o_instr_valid}, 32'd1);
    chk("wr_instr", {16'd0, o_instr},       32'h5A5A);
    chk("wr_pc",    {16'd0, o_pc},          32'hFFFF);
    i_instr_ready = 1'b1;
    step();
    i_instr_ready = 1'b0;
    chk("wr_req0",  {31'd0, o_mem_req},  32'd1);
    chk("wr_addr0", {16'd0, o_mem_addr}, 32'h0);
    chk("wr_npc0",  {16'd0, o_npc},      32'h1);
    step();

    // Reset while a fetch at 9 waits for its ack; acks during reset ignored.
    i_jump_valid = 1'b1;
    i_jump_addr  = 16'h0009;
    ack_en       = 1'b0;
    step();
    i_jump_valid = 1'b0;
    chk("rs_req",  {31'd0, o_mem_req},  32'd1);
    chk("rs_addr", {16'd0, o_mem_addr}, 32'h9);
    #3;
    rst_n     = 1'b1;
    force_ack = 1'b1;
    #1;
    chk("rs_async_req",  {31'd0, o_mem_req},  32'd0);
    chk("rs_async_addr", {16'd0, o_mem_addr}, 32'h0);
    chk("rs_async_npc",  {16'd0, o_npc},      32'h1);
    repeat (3) step();
    rst_n  = 1'b0;
    ack_en = 1'b1;
    step();
    force_ack = 1'b0;
    chk("rs_post_req",   {31'd0, o_mem_req},     32'd1);
    chk("rs_post_addr",  {16'd0, o_mem_addr},    32'h0);
    chk("rs_post_valid", {31'd0, o_instr_valid}, 32'd0);
    step();
    chk("rs_post_instr", {16'd0, o_instr}, 32'hA5A5);
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    bad++;
    $display("FAIL timeout t=%0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
